up_axi_master: RTL and testbench
================================

UP_AXI_MASTER -- requirements
Module: up_axi_master
Interface
REQ-001 AXI_BASE_ADDR, default 32'h00000000, SHALL be ORed into every generated AXI byte address.
REQ-002 TIMEOUT_CYCLES, default 255 (range 1..65535), SHALL set max cycles waited per transaction before abort.
REQ-003 up_clk  in  1  SHALL clock all logic.
REQ-004 up_rstn  in  1  SHALL be reset, asynchronous, active-low.
REQ-005 up_wreq  in  1  SHALL be the write request pulse.
REQ-006 up_waddr  in  14  SHALL be the write word address.
REQ-007 up_wdata  in  32  SHALL be the write data.
REQ-008 up_wack  out  1  SHALL be the write completion pulse.
REQ-009 up_rreq  in  1  SHALL be the read request pulse.
REQ-010 up_raddr  in  14  SHALL be the read word address.
REQ-011 up_rdata  out  32  SHALL be the read data, valid with up_rack.
REQ-012 up_rack  out  1  SHALL be the read completion pulse.
REQ-013 up_err  out  1  SHALL pulse with ack on error response or timeout.
REQ-014 m_axi_awvalid  out  1  SHALL be the write address valid.
REQ-015 m_axi_awaddr  out  32  SHALL be the write byte address.
REQ-016 m_axi_awready  in  1  SHALL be the write address ready.
REQ-017 m_axi_wvalid  out  1  SHALL be the write data valid.
REQ-018 m_axi_wdata  out  32  SHALL be the write data.
REQ-019 m_axi_wstrb  out  4  SHALL be constant 4'hf.
REQ-020 m_axi_wready  in  1  SHALL be the write data ready.
REQ-021 m_axi_bvalid  in  1  SHALL be the write response valid.
REQ-022 m_axi_bresp  in  2  SHALL be the write response code.
REQ-023 m_axi_bready  out  1  SHALL be the write response ready.
REQ-024 m_axi_arvalid  out  1  SHALL be the read address valid.
REQ-025 m_axi_araddr  out  32  SHALL be the read byte address.
REQ-026 m_axi_arready  in  1  SHALL be the read address ready.
REQ-027 m_axi_rvalid  in  1  SHALL be the read data valid.
REQ-028 m_axi_rdata  in  32  SHALL be the read data.
REQ-029 m_axi_rresp  in  2  SHALL be the read response code.
REQ-030 m_axi_rready  out  1  SHALL be the read data ready.
Function
REQ-031 Addressing SHALL be AXI_BASE_ADDR | {16'd0, addr, 2'b00}; all AXI outputs SHALL be registered.
REQ-032 FSM states SHALL be IDLE, WR_REQ (AW/W outstanding), WR_RESP, RD_REQ, RD_RESP; one transaction outstanding at a time.
REQ-033 IDLE + up_wreq in cycle N -> WR_REQ; awvalid, wvalid, address and data driven from cycle N+1.
REQ-034 IDLE + up_rreq (no wreq) in cycle N -> RD_REQ; arvalid driven from cycle N+1.
REQ-035 Simultaneous wreq and rreq in IDLE: write first; read address latched and issued on the cycle after up_wack.
REQ-036 awvalid and wvalid SHALL each drop independently the cycle after their own handshake; WR_RESP entered once both are done; bready=1 only in WR_RESP.
REQ-037 arvalid SHALL drop after its handshake -> RD_RESP; rready=1 only in RD_RESP.
REQ-038 The cycle after bvalid&bready: up_wack=1 for one cycle; up_err=1 if bresp!=0; back to IDLE (or pending read).
REQ-039 The cycle after rvalid&rready: up_rack=1 for one cycle, up_rdata=rdata, held until next rack; up_err=1 if rresp!=0.
REQ-040 A 16-bit timeout counter SHALL clear on leaving IDLE and increment each non-IDLE cycle; when it equals TIMEOUT_CYCLES, all valids/readys drop, ack + up_err pulse, up_rdata=32'hdeaddead for reads, then IDLE.
REQ-041 Requests arriving outside IDLE (other than REQ-035) SHALL be ignored, with no ack.
Reset
REQ-042 While up_rstn=0, all outputs SHALL be 0 except wstrb=4'hf; the FSM SHALL be IDLE, any pending read cleared; an in-flight transaction is abandoned with no ack.
Verification
REQ-043 wreq addr 14'h0010 data 32'h12345678, slave ready immediately, bresp=0 -> awaddr 32'h40, one up_wack, up_err=0.
REQ-044 rreq addr 14'h0003, arready delayed 3 cycles, rdata 32'hcafef00d -> araddr 32'h0c, up_rack with up_rdata 32'hcafef00d.
REQ-045 wready before awready by 2 cycles -> wvalid drops first, single bready handshake, single up_wack.
REQ-046 Simultaneous wreq/rreq -> write completes, then read issued; wack precedes rack; exactly one of each.
REQ-047 TIMEOUT_CYCLES=8, slave never responds to a read -> rack+up_err after 8 cycles, up_rdata 32'hdeaddead; rresp=2'b10 on a later read -> up_err with rack.

Source files
------------

// File: rtl/up_axi_master_if.sv
// AXI4-Lite master bus bundle used by up_axi_master.
interface up_axi_master_if;
  logic        awvalid;
  logic [31:0] awaddr;
  logic        awready;
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready;
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rready;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/up_axi_master.sv
// Bridges single-word up_* register requests onto an AXI4-Lite master port,
// one transaction at a time, with a per-transaction timeout.
module up_axi_master #(
  parameter logic [31:0] AXI_BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        up_clk,
  input  logic        up_rstn,
  input  logic        up_wreq,
  input  logic [13:0] up_waddr,
  input  logic [31:0] up_wdata,
  output logic        up_wack,
  input  logic        up_rreq,
  input  logic [13:0] up_raddr,
  output logic [31:0] up_rdata,
  output logic        up_rack,
  output logic        up_err,
  up_axi_master_if.master m_axi
);

  localparam int unsigned CNT_W    = 16;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [31:0] TO_RDATA = 32'hdead_dead;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_RESP = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             awvalid_q, awvalid_d;
  logic             wvalid_q, wvalid_d;
  logic             bready_q, bready_d;
  logic             arvalid_q, arvalid_d;
  logic             rready_q, rready_d;
  logic [31:0]      awaddr_q, awaddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      araddr_q, araddr_d;
  logic             rd_pend_q, rd_pend_d;
  logic [13:0]      pend_addr_q, pend_addr_d;
  logic             wack_d, rack_d, err_d;
  logic [31:0]      rdata_d;
  logic             timeout;

  function automatic logic [31:0] byte_addr(input logic [13:0] word_addr);
    return AXI_BASE_ADDR | {16'd0, word_addr, 2'b00};
  endfunction

  assign m_axi.awvalid = awvalid_q;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = 4'hf;
  assign m_axi.bready  = bready_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.rready  = rready_q;

  assign timeout = (state_q != ST_IDLE) && (cnt_q == TO_LIMIT);

  // Next-state and next-output logic; a timeout overrides any channel progress.
  always_comb begin
    state_d     = state_q;
    cnt_d       = (state_q == ST_IDLE) ? '0 : cnt_q + CNT_W'(1);
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    araddr_d    = araddr_q;
    rd_pend_d   = rd_pend_q;
    pend_addr_d = pend_addr_q;
    wack_d      = 1'b0;
    rack_d      = 1'b0;
    err_d       = 1'b0;
    rdata_d     = up_rdata;

    case (state_q)
      ST_IDLE: begin
        if (rd_pend_q) begin
          // Read deferred behind a simultaneous write goes out first.
          rd_pend_d = 1'b0;
          arvalid_d = 1'b1;
          araddr_d  = byte_addr(pend_addr_q);
          state_d   = ST_RD_REQ;
        end else if (up_wreq) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = byte_addr(up_waddr);
          wdata_d   = up_wdata;
          state_d   = ST_WR_REQ;
          if (up_rreq) begin
            rd_pend_d   = 1'b1;
            pend_addr_d = up_raddr;
          end
        end else if (up_rreq) begin
          arvalid_d = 1'b1;
          araddr_d  = byte_addr(up_raddr);
          state_d   = ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
        if ((!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready)) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (m_axi.bvalid) begin
          bready_d = 1'b0;
          wack_d   = 1'b1;
          err_d    = (m_axi.bresp != 2'b00);
          state_d  = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (m_axi.rvalid) begin
          rready_d = 1'b0;
          rack_d   = 1'b1;
          rdata_d  = m_axi.rdata;
          err_d    = (m_axi.rresp != 2'b00);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      err_d     = 1'b1;
      state_d   = ST_IDLE;
      if (state_q == ST_WR_REQ || state_q == ST_WR_RESP) begin
        wack_d = 1'b1;
        rack_d = 1'b0;
      end else begin
        wack_d  = 1'b0;
        rack_d  = 1'b1;
        rdata_d = TO_RDATA;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      araddr_q    <= '0;
      rd_pend_q   <= 1'b0;
      pend_addr_q <= '0;
      up_wack     <= 1'b0;
      up_rack     <= 1'b0;
      up_err      <= 1'b0;
      up_rdata    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      araddr_q    <= araddr_d;
      rd_pend_q   <= rd_pend_d;
      pend_addr_q <= pend_addr_d;
      up_wack     <= wack_d;
      up_rack     <= rack_d;
      up_err      <= err_d;
      up_rdata    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_up_axi_master.sv
// Randomized self-checking bench for up_axi_master with a timing/response reference model.
module tb_up_axi_master;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int T   = 8;
  localparam int LIM = 40;

  logic        up_clk;
  logic        up_rstn;
  logic        up_wreq;
  logic [13:0] up_waddr;
  logic [31:0] up_wdata;
  logic        up_wack;
  logic        up_rreq;
  logic [13:0] up_raddr;
  logic [31:0] up_rdata;
  logic        up_rack;
  logic        up_err;

  up_axi_master_if m ();

  up_axi_master #(.AXI_BASE_ADDR(BASE), .TIMEOUT_CYCLES(T)) dut (
    .up_clk  (up_clk),
    .up_rstn (up_rstn),
    .up_wreq (up_wreq),
    .up_waddr(up_waddr),
    .up_wdata(up_wdata),
    .up_wack (up_wack),
    .up_rreq (up_rreq),
    .up_raddr(up_raddr),
    .up_rdata(up_rdata),
    .up_rack (up_rack),
    .up_err  (up_err),
    .m_axi   (m)
  );

  initial up_clk = 1'b0;
  always #5 up_clk = ~up_clk;

  int total = 0;
  int bad   = 0;

  // Bus observation: handshakes at the clock edge, up_* events half a cycle later.
  int cyc = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  int aw_hs_cyc = 0, w_hs_cyc = 0;
  logic [31:0] aw_addr = '0, w_data = '0, ar_addr = '0;
  int wack_n = 0, rack_n = 0, err_n = 0, wack_cyc = 0, rack_cyc = 0;
  logic wack_err = 1'b0, rack_err = 1'b0;
  logic [31:0] rack_data = '0;
  int aw_rise_n = 0, aw_rise_cyc = 0, ar_rise_n = 0, ar_rise_cyc = 0;
  logic aw_prev = 1'b0, ar_prev = 1'b0;

  always @(posedge up_clk) begin
    cyc <= cyc + 1;
    if (m.awvalid && m.awready) begin aw_hs <= aw_hs + 1; aw_addr <= m.awaddr; aw_hs_cyc <= cyc; end
    if (m.wvalid && m.wready)   begin w_hs <= w_hs + 1; w_data <= m.wdata; w_hs_cyc <= cyc; end
    if (m.bvalid && m.bready)   b_hs <= b_hs + 1;
    if (m.arvalid && m.arready) begin ar_hs <= ar_hs + 1; ar_addr <= m.araddr; end
    if (m.rvalid && m.rready)   r_hs <= r_hs + 1;
  end

  always @(negedge up_clk) begin
    if (up_wack) begin wack_n <= wack_n + 1; wack_cyc <= cyc; wack_err <= up_err; end
    if (up_rack) begin rack_n <= rack_n + 1; rack_cyc <= cyc; rack_err <= up_err; rack_data <= up_rdata; end
    if (up_err) err_n <= err_n + 1;
    if (m.awvalid && !aw_prev) begin aw_rise_n <= aw_rise_n + 1; aw_rise_cyc <= cyc; end
    if (m.arvalid && !ar_prev) begin ar_rise_n <= ar_rise_n + 1; ar_rise_cyc <= cyc; end
    aw_prev <= m.awvalid;
    ar_prev <= m.arvalid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] baddr(input logic [13:0] a);
    return BASE | {16'd0, a, 2'b00};
  endfunction

  task automatic req(input logic w, input logic r, input logic [13:0] wa,
                     input logic [31:0] wd, input logic [13:0] ra);
    up_wreq = w; up_rreq = r; up_waddr = wa; up_wdata = wd; up_raddr = ra;
    @(negedge up_clk);
    up_wreq = 1'b0; up_rreq = 1'b0;
  endtask

  task automatic serve_aw(input int dly);
    int n = 0;
    while (!m.awvalid && n < LIM) begin @(negedge up_clk); n++; end
    if (m.awvalid) begin
      repeat (dly) @(negedge up_clk);
      m.awready = 1'b1;
      @(negedge up_clk);
      m.awready = 1'b0;
    end
  endtask

  task automatic serve_w(input int dly);
    int n = 0;
    while (!m.wvalid && n < LIM) begin @(negedge up_clk); n++; end
    if (m.wvalid) begin
      repeat (dly) @(negedge up_clk);
      m.wready = 1'b1;
      @(negedge up_clk);
      m.wready = 1'b0;
    end
  endtask

  task automatic serve_b(input int dly, input logic [1:0] resp);
    int n = 0;
    while (!m.bready && n < LIM) begin @(negedge up_clk); n++; end
    if (m.bready) begin
      repeat (dly) @(negedge up_clk);
      m.bvalid = 1'b1; m.bresp = resp; n = 0;
      do begin @(negedge up_clk); n++; end while (m.bready && n < LIM);
      m.bvalid = 1'b0; m.bresp = 2'b00;
    end
  endtask

  task automatic serve_ar(input int dly);
    int n = 0;
    while (!m.arvalid && n < LIM) begin @(negedge up_clk); n++; end
    if (m.arvalid) begin
      repeat (dly) @(negedge up_clk);
      m.arready = 1'b1;
      @(negedge up_clk);
      m.arready = 1'b0;
    end
  endtask

  task automatic serve_r(input int dly, input logic [31:0] data, input logic [1:0] resp);
    int n = 0;
    while (!m.rready && n < LIM) begin @(negedge up_clk); n++; end
    if (m.rready) begin
      repeat (dly) @(negedge up_clk);
      m.rvalid = 1'b1; m.rdata = data; m.rresp = resp; n = 0;
      do begin @(negedge up_clk); n++; end while (m.rready && n < LIM);
      m.rvalid = 1'b0; m.rdata = '0; m.rresp = 2'b00;
    end
  endtask

  task automatic wait_cnt(input int which, input int base);
    int n = 0;
    while (((which == 0) ? wack_n : rack_n) == base && n < LIM) begin @(negedge up_clk); n++; end
    repeat (3) @(negedge up_clk);
  endtask

  // Expected timing: valids rise one cycle after the request, ack one cycle after the
  // final handshake, so ack = req + 3 + address/data wait + response wait.
  task automatic run_write(input logic [13:0] a, input logic [31:0] d, input int ad,
                           input int wd, input int bd, input logic [1:0] br);
    int c0 = cyc, w0 = wack_n, r0 = rack_n, e0 = err_n, b0 = b_hs;
    int mx = (ad > wd) ? ad : wd;
    fork
      req(1'b1, 1'b0, a, d, 14'd0);
      serve_aw(ad);
      serve_w(wd);
      serve_b(bd, br);
    join
    wait_cnt(0, w0);
    check("wr_awaddr", aw_addr, baddr(a));
    check("wr_wdata", w_data, d);
    check("wr_aw_start", 32'(aw_rise_cyc), 32'(c0 + 1));
    check("wr_wack_n", 32'(wack_n - w0), 32'd1);
    check("wr_rack_n", 32'(rack_n - r0), 32'd0);
    check("wr_b_hs", 32'(b_hs - b0), 32'd1);
    check("wr_lat", 32'(wack_cyc), 32'(c0 + 3 + mx + bd));
    check("wr_err", 32'(wack_err), 32'(br != 2'b00));
    check("wr_err_n", 32'(err_n - e0), 32'(br != 2'b00));
  endtask

  task automatic run_read(input logic [13:0] a, input int ad, input int rd,
                          input logic [31:0] data, input logic [1:0] rr);
    int c0 = cyc, w0 = wack_n, r0 = rack_n, e0 = err_n;
    fork
      req(1'b0, 1'b1, 14'd0, 32'd0, a);
      serve_ar(ad);
      serve_r(rd, data, rr);
    join
    wait_cnt(1, r0);
    check("rd_araddr", ar_addr, baddr(a));
    check("rd_ar_start", 32'(ar_rise_cyc), 32'(c0 + 1));
    check("rd_rack_n", 32'(rack_n - r0), 32'd1);
    check("rd_wack_n", 32'(wack_n - w0), 32'd0);
    check("rd_lat", 32'(rack_cyc), 32'(c0 + 3 + ad + rd));
    check("rd_data", rack_data, data);
    check("rd_err", 32'(rack_err), 32'(rr != 2'b00));
    check("rd_err_n", 32'(err_n - e0), 32'(rr != 2'b00));
  endtask

  task automatic run_both(input logic [13:0] wa, input logic [31:0] d, input logic [13:0] ra,
                          input int ad, input int wd, input int bd, input int ard, input int rd,
                          input logic [31:0] data);
    int c0 = cyc, w0 = wack_n, r0 = rack_n;
    int mx = (ad > wd) ? ad : wd;
    fork
      req(1'b1, 1'b1, wa, d, ra);
      serve_aw(ad);
      serve_w(wd);
      serve_b(bd, 2'b00);
      serve_ar(ard);
      serve_r(rd, data, 2'b00);
    join
    wait_cnt(1, r0);
    check("both_wack_n", 32'(wack_n - w0), 32'd1);
    check("both_rack_n", 32'(rack_n - r0), 32'd1);
    check("both_wlat", 32'(wack_cyc), 32'(c0 + 3 + mx + bd));
    check("both_ar_start", 32'(ar_rise_cyc), 32'(wack_cyc + 1));
    check("both_rlat", 32'(rack_cyc), 32'(wack_cyc + 3 + ard + rd));
    check("both_awaddr", aw_addr, baddr(wa));
    check("both_araddr", ar_addr, baddr(ra));
    check("both_rdata", rack_data, data);
  endtask

  task automatic check_idle_outs(input string tag);
    check(tag, {24'd0, up_wack, up_rack, up_err, m.awvalid, m.wvalid, m.bready, m.arvalid, m.rready}, 32'd0);
    check({tag, "_rdata"}, up_rdata, 32'd0);
    check({tag, "_awaddr"}, m.awaddr | m.araddr | m.wdata, 32'd0);
    check({tag, "_wstrb"}, 32'(m.wstrb), 32'hf);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, w0, r0, a0;
    up_rstn = 1'b0; up_wreq = 1'b0; up_rreq = 1'b0;
    up_waddr = '0; up_wdata = '0; up_raddr = '0;
    m.awready = 1'b0; m.wready = 1'b0; m.bvalid = 1'b0; m.bresp = 2'b00;
    m.arready = 1'b0; m.rvalid = 1'b0; m.rdata = '0; m.rresp = 2'b00;
    repeat (3) @(negedge up_clk);
    check_idle_outs("rst");
    up_rstn = 1'b1;
    @(negedge up_clk);

    run_write(14'h0010, 32'h1234_5678, 0, 0, 0, 2'b00);
    check("wr_awaddr_0x40", aw_addr, BASE | 32'h40);
    run_read(14'h0003, 3, 0, 32'hcafe_f00d, 2'b00);
    check("rd_araddr_0x0c", ar_addr, BASE | 32'h0c);
    run_write(14'h0155, 32'h0bad_cafe, 2, 0, 1, 2'b00);
    check("wr_w_first", 32'(aw_hs_cyc - w_hs_cyc), 32'd2);
    run_both(14'h0021, 32'h5555_aaaa, 14'h0042, 1, 2, 0, 1, 1, 32'h1357_9bdf);

    // Read with no slave response: aborted by the timeout.
    c0 = cyc; r0 = rack_n; a0 = ar_hs;
    req(1'b0, 1'b1, 14'd0, 32'd0, 14'h0007);
    wait_cnt(1, r0);
    check("to_rack_n", 32'(rack_n - r0), 32'd1);
    check("to_lat", 32'(rack_cyc), 32'(c0 + T + 2));
    check("to_err", 32'(rack_err), 32'd1);
    check("to_rdata", rack_data, 32'hdead_dead);
    check("to_ar_hs", 32'(ar_hs - a0), 32'd0);
    check("to_arvalid", 32'(m.arvalid), 32'd0);
    run_read(14'h0009, 0, 1, 32'h0f0f_0f0f, 2'b10);

    // Write whose response never comes.
    c0 = cyc; w0 = wack_n;
    fork
      req(1'b1, 1'b0, 14'h0011, 32'h7777_0000, 14'd0);
      serve_aw(0);
      serve_w(1);
    join
    wait_cnt(0, w0);
    check("wto_lat", 32'(wack_cyc), 32'(c0 + T + 2));
    check("wto_err", 32'(wack_err), 32'd1);
    check("wto_bready", 32'(m.bready), 32'd0);

    // Write request during a read is dropped.
    c0 = cyc; w0 = wack_n; r0 = rack_n; a0 = aw_rise_n;
    fork
      req(1'b0, 1'b1, 14'd0, 32'd0, 14'h0030);
      serve_ar(1);
      serve_r(2, 32'h2468_ace0, 2'b00);
      begin repeat (2) @(negedge up_clk); req(1'b1, 1'b0, 14'h0031, 32'h1111_1111, 14'd0); end
    join
    wait_cnt(1, r0);
    repeat (T + 4) @(negedge up_clk);
    check("ign_rlat", 32'(rack_cyc), 32'(c0 + 3 + 1 + 2));
    check("ign_wack_n", 32'(wack_n - w0), 32'd0);
    check("ign_aw_rise", 32'(aw_rise_n - a0), 32'd0);

    for (int i = 0; i < 24; i++) begin
      int kind = int'($urandom_range(0, 2));
      logic [13:0] a  = 14'($urandom);
      logic [13:0] a2 = 14'($urandom);
      logic [31:0] d  = $urandom;
      if (kind == 0)
        run_write(a, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      else if (kind == 1)
        run_read(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), d,
                 2'($urandom_range(0, 3)));
      else
        run_both(a, d, a2, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), ~d);
    end

    // Reset in the middle of a write with a read pending abandons both.
    w0 = wack_n; r0 = rack_n; a0 = ar_rise_n;
    req(1'b1, 1'b1, 14'h0050, 32'hffff_0000, 14'h0051);
    repeat (2) @(negedge up_clk);
    up_rstn = 1'b0;
    #1;
    check_idle_outs("rst_mid");
    repeat (2) @(negedge up_clk);
    up_rstn = 1'b1;
    repeat (T + 8) @(negedge up_clk);
    check("rst_mid_wack", 32'(wack_n - w0), 32'd0);
    check("rst_mid_rack", 32'(rack_n - r0), 32'd0);
    check("rst_mid_ar", 32'(ar_rise_n - a0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
